// File: rtl/sat_pkg.sv
// sat_pkg: shared definitions for the sat_pipe saturator/rounder.
//   SAT_UCLAMP / SAT_SSAT / SAT_OFFBIN : output mode encodings (2'b11 behaves as SAT_SSAT)
//   ch_width()                         : channel-tag width for a given channel count
package sat_pkg;

  localparam logic [1:0] SAT_UCLAMP = 2'b00;
  localparam logic [1:0] SAT_SSAT   = 2'b01;
  localparam logic [1:0] SAT_OFFBIN = 2'b10;

  // A single channel still needs a 1-bit tag so the ports never collapse to zero width.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_pipe_if.sv
// sat_pipe_if: input and output sample streams of sat_pipe.
//   Input stream : in_valid, in_ready, in_data (signed ISZ), in_ch (CHW), mode (2)
//   Output stream: out_valid, out_ready, out_data (OSZ), out_ch (CHW), out_hi, out_lo
//   slave  modport: the sat_pipe side
//   master modport: the producer/consumer side
interface sat_pipe_if #(
  parameter int ISZ = 17,
  parameter int OSZ = 12,
  parameter int CHW = 2
);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [ISZ-1:0] in_data;
  logic [CHW-1:0]        in_ch;
  logic [1:0]            mode;

  logic                  out_valid;
  logic                  out_ready;
  logic [OSZ-1:0]        out_data;
  logic [CHW-1:0]        out_ch;
  logic                  out_hi;
  logic                  out_lo;

  modport slave (
    input  in_valid, in_data, in_ch, mode, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_hi, out_lo
  );

  modport master (
    output in_valid, in_data, in_ch, mode, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_hi, out_lo
  );

endinterface

// File: rtl/sat_core.sv
// sat_core: combinational saturation of a rounded sample to OSZ bits.
//   t    in  TW   rounded signed sample (TW > OSZ)
//   mode in  2    SAT_UCLAMP, SAT_SSAT, SAT_OFFBIN (2'b11 treated as SAT_SSAT)
//   data out OSZ  saturated result
//   hi   out 1    clipped at the upper bound
//   lo   out 1    clipped at the lower bound (never together with hi)
module sat_core
  import sat_pkg::*;
#(
  parameter int TW  = 18,
  parameter int OSZ = 12
) (
  input  logic signed [TW-1:0] t,
  input  logic [1:0]           mode,
  output logic [OSZ-1:0]       data,
  output logic                 hi,
  output logic                 lo
);

  // Bounds expressed at the full width of t so the compares are exact.
  localparam logic signed [TW-1:0] U_MAX = {{(TW-OSZ){1'b0}}, {OSZ{1'b1}}};
  localparam logic signed [TW-1:0] S_MAX = {{(TW-OSZ+1){1'b0}}, {(OSZ-1){1'b1}}};
  localparam logic signed [TW-1:0] S_MIN = {{(TW-OSZ+1){1'b1}}, {(OSZ-1){1'b0}}};

  always_comb begin
    data = t[OSZ-1:0];
    hi   = 1'b0;
    lo   = 1'b0;
    if (mode == SAT_UCLAMP) begin
      if (t[TW-1]) begin
        lo   = 1'b1;
        data = '0;
      end else if (t > U_MAX) begin
        hi   = 1'b1;
        data = '1;
      end
    end else begin
      if (t > S_MAX) begin
        hi   = 1'b1;
        data = {1'b0, {(OSZ-1){1'b1}}};
      end else if (t < S_MIN) begin
        lo   = 1'b1;
        data = {1'b1, {(OSZ-1){1'b0}}};
      end
      // Offset-binary is the two's-complement result with the sign bit flipped.
      if (mode == SAT_OFFBIN) begin
        data[OSZ-1] = ~data[OSZ-1];
      end
    end
  end

endmodule

// File: rtl/sat_pipe.sv
// sat_pipe: two-stage saturator/rounder for time-multiplexed channel streams.
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   bus       if   sat_pipe_if.slave: input stream (valid/ready/data/ch/mode)
//                  and output stream (valid/ready/data/ch/hi/lo)
//   clr       in   clear sticky flags and event counter
//   sat_flags out  per-channel sticky saturation flags
//   sat_count out  saturated-beat counter, holds at all-ones
// Stage 1 registers the rounded sample; stage 2 saturates and registers outputs.
module sat_pipe
  import sat_pkg::*;
#(
  parameter int ISZ = 17,
  parameter int OSZ = 12,
  parameter int RSH = 0,
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  sat_pipe_if.slave      bus,
  input  logic           clr,
  output logic [NCH-1:0] sat_flags,
  output logic [CW-1:0]  sat_count
);

  localparam int CHW = ch_width(NCH);
  localparam int TW  = ISZ + 1 - RSH;

  // Whole pipe advances together; it only freezes while the output beat waits.
  logic en;
  assign en           = ~(bus.out_valid & ~bus.out_ready);
  assign bus.in_ready = en;

  // Rounding: one guard bit on top keeps the +half from overflowing.
  logic signed [ISZ:0]  ext;
  logic signed [TW-1:0] t_in;
  assign ext = {bus.in_data[ISZ-1], bus.in_data};

  if (RSH > 0) begin : g_round
    localparam logic signed [ISZ:0] HALF = (ISZ+1)'(1) <<< (RSH - 1);
    logic signed [ISZ:0] sum;
    assign sum  = ext + HALF;
    assign t_in = TW'(sum >>> RSH);
  end else begin : g_pass
    assign t_in = ext;
  end

  // Stage 1 state
  logic                 s1_valid;
  logic signed [TW-1:0] s1_t;
  logic [CHW-1:0]       s1_ch;
  logic [1:0]           s1_mode;

  logic [OSZ-1:0] core_data;
  logic           core_hi;
  logic           core_lo;

  sat_core #(
    .TW  (TW),
    .OSZ (OSZ)
  ) u_core (
    .t    (s1_t),
    .mode (s1_mode),
    .data (core_data),
    .hi   (core_hi),
    .lo   (core_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid      <= 1'b0;
      s1_t          <= '0;
      s1_ch         <= '0;
      s1_mode       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_hi    <= 1'b0;
      bus.out_lo    <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_t    <= t_in;
        s1_ch   <= bus.in_ch;
        s1_mode <= bus.mode;
      end
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= core_data;
        bus.out_ch   <= s1_ch;
        bus.out_hi   <= core_hi;
        bus.out_lo   <= core_lo;
      end
    end
  end

  // A saturation event is counted exactly once: on the edge its beat enters stage 2.
  logic           sat_evt;
  logic [NCH-1:0] hit;
  assign sat_evt = en & s1_valid & (core_hi | core_lo);

  // Tags >= NCH match no channel, so they never touch the flags.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_hit
      assign hit[gi] = sat_evt && (s1_ch == CHW'(gi));
    end
  endgenerate

  // The event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_flags <= '0;
      sat_count <= '0;
    end else begin
      sat_flags <= (clr ? '0 : sat_flags) | hit;
      if (clr) begin
        sat_count <= sat_evt ? CW'(1) : '0;
      end else if (sat_evt && (sat_count != '1)) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sat_pipe.sv
// tb_sat_pipe: two sat_pipe instances (RSH=0/CW=4 and RSH=2/CW=16) fed the
// same stimulus. Directed table vectors, a randomized backpressure run checked
// against an arithmetic reference model, plus statistics and reset sequences.
module tb_sat_pipe;
  import sat_pkg::*;

  localparam int ISZ = 17;
  localparam int OSZ = 12;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b1;
  logic                  clr = 1'b0;
  logic signed [ISZ-1:0] in_data = '0;
  logic [CHW-1:0]        in_ch = '0;
  logic [1:0]            mode = '0;
  logic [NCH-1:0]        flags_a, flags_b;
  logic [3:0]            count_a;
  logic [15:0]           count_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sat_pipe_if #(.ISZ(ISZ), .OSZ(OSZ), .CHW(CHW)) ifa ();
  sat_pipe_if #(.ISZ(ISZ), .OSZ(OSZ), .CHW(CHW)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.in_ch     = in_ch;
  assign ifa.mode      = mode;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.in_ch     = in_ch;
  assign ifb.mode      = mode;
  assign ifb.out_ready = out_ready;

  sat_pipe #(.ISZ(ISZ), .OSZ(OSZ), .RSH(0), .NCH(NCH), .CW(4)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (ifa.slave),
    .clr       (clr),
    .sat_flags (flags_a),
    .sat_count (count_a)
  );

  sat_pipe #(.ISZ(ISZ), .OSZ(OSZ), .RSH(2), .NCH(NCH), .CW(16)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (ifb.slave),
    .clr       (clr),
    .sat_flags (flags_b),
    .sat_count (count_b)
  );

  typedef struct packed {
    logic [OSZ-1:0] data;
    logic           hi;
    logic           lo;
    logic [CHW-1:0] ch;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Reference: floor((x + half) / 2^rsh), then clamp to the mode's range.
  function automatic exp_t model(input int x, input int rsh, input logic [1:0] m,
                                 input logic [CHW-1:0] ch);
    int   t, num, den, d, umax, smax, smin;
    exp_t e;
    umax = (1 << OSZ) - 1;
    smax = (1 << (OSZ - 1)) - 1;
    smin = -(1 << (OSZ - 1));
    if (rsh == 0) begin
      t = x;
    end else begin
      num = x + (1 << (rsh - 1));
      den = 1 << rsh;
      t = (num >= 0) ? num / den : -((-num + den - 1) / den);
    end
    e.hi = 1'b0;
    e.lo = 1'b0;
    if (m == 2'd0) begin
      if (t < 0) begin e.lo = 1'b1; t = 0; end
      else if (t > umax) begin e.hi = 1'b1; t = umax; end
    end else begin
      if (t > smax) begin e.hi = 1'b1; t = smax; end
      else if (t < smin) begin e.lo = 1'b1; t = smin; end
    end
    d = t & umax;
    if (m == 2'd2) d = d ^ (1 << (OSZ - 1));
    e.data = OSZ'(d);
    e.ch   = ch;
    return e;
  endfunction

  // Scoreboard: expected beats queued on acceptance, popped on output transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ifa.out_valid && out_ready) begin
        if (qa.size() == 0) check("a_unexpected_beat", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_beat_data", int'(ifa.out_data), int'(e.data));
          check("a_beat_hilo", int'({ifa.out_hi, ifa.out_lo}), int'({e.hi, e.lo}));
          check("a_beat_ch", int'(ifa.out_ch), int'(e.ch));
        end
      end
      if (ifb.out_valid && out_ready) begin
        if (qb.size() == 0) check("b_unexpected_beat", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_beat_data", int'(ifb.out_data), int'(e.data));
          check("b_beat_hilo", int'({ifb.out_hi, ifb.out_lo}), int'({e.hi, e.lo}));
          check("b_beat_ch", int'(ifb.out_ch), int'(e.ch));
        end
      end
      check("a_in_ready_rule", int'(ifa.in_ready), int'(!(ifa.out_valid && !out_ready)));
      if (in_valid && ifa.in_ready) qa.push_back(model(int'(in_data), 0, mode, in_ch));
      if (in_valid && ifb.in_ready) qb.push_back(model(int'(in_data), 2, mode, in_ch));
    end
  end

  typedef struct {
    bit         use_b;
    logic [1:0] m;
    int         x;
    int         d;
    int         hi;
    int         lo;
  } vec_t;

  vec_t vt[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input int x, input logic [CHW-1:0] ch);
    in_valid = 1'b1;
    mode     = m;
    in_data  = ISZ'(x);
    in_ch    = ch;
  endtask

  initial begin
    vt[0]  = '{1'b0, SAT_UCLAMP, -5,    'h000, 0, 1};
    vt[1]  = '{1'b0, SAT_UCLAMP, 5000,  'hFFF, 1, 0};
    vt[2]  = '{1'b0, SAT_UCLAMP, 1234,  1234,  0, 0};
    vt[3]  = '{1'b0, SAT_SSAT,   3000,  'h7FF, 1, 0};
    vt[4]  = '{1'b0, SAT_SSAT,   -3000, 'h800, 0, 1};
    vt[5]  = '{1'b0, SAT_SSAT,   -2048, 'h800, 0, 0};
    vt[6]  = '{1'b0, SAT_OFFBIN, 0,     'h800, 0, 0};
    vt[7]  = '{1'b0, SAT_OFFBIN, -3000, 'h000, 0, 1};
    vt[8]  = '{1'b0, SAT_OFFBIN, 3000,  'hFFF, 1, 0};
    vt[9]  = '{1'b0, 2'b11,      3000,  'h7FF, 1, 0};
    vt[10] = '{1'b1, SAT_SSAT,   7,     'h002, 0, 0};
    vt[11] = '{1'b1, SAT_SSAT,   -7,    'hFFE, 0, 0};
    vt[12] = '{1'b1, SAT_SSAT,   6,     'h002, 0, 0};
    vt[13] = '{1'b1, SAT_SSAT,   65535, 'h7FF, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid_a", int'(ifa.out_valid), 0);
    check("rst_out_data_a", int'(ifa.out_data), 0);
    check("rst_out_ch_a", int'(ifa.out_ch), 0);
    check("rst_hilo_a", int'({ifa.out_hi, ifa.out_lo}), 0);
    check("rst_flags_a", int'(flags_a), 0);
    check("rst_count_a", int'(count_a), 0);
    check("rst_out_valid_b", int'(ifb.out_valid), 0);
    check("rst_count_b", int'(count_b), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", int'(ifa.in_ready), 1);
    tick();

    // Directed vectors with latency check
    for (int i = 0; i < 14; i++) begin
      send(vt[i].m, vt[i].x, CHW'(i));
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_1cyc_valid", int'(vt[i].use_b ? ifb.out_valid : ifa.out_valid), 0);
      @(negedge clk);
      check("latency_2cyc_valid", int'(vt[i].use_b ? ifb.out_valid : ifa.out_valid), 1);
      check("vec_data", int'(vt[i].use_b ? ifb.out_data : ifa.out_data), vt[i].d);
      check("vec_hi", int'(vt[i].use_b ? ifb.out_hi : ifa.out_hi), vt[i].hi);
      check("vec_lo", int'(vt[i].use_b ? ifb.out_lo : ifa.out_lo), vt[i].lo);
      $display("vec %0d dut=%s mode=%0d in=%0d out=0x%03h hi=%0b lo=%0b", i,
               vt[i].use_b ? "b" : "a", vt[i].m, vt[i].x,
               vt[i].use_b ? ifb.out_data : ifa.out_data,
               vt[i].use_b ? ifb.out_hi : ifa.out_hi,
               vt[i].use_b ? ifb.out_lo : ifa.out_lo);
      if (i == 2) check("count_after_uclamp", int'(count_a), 2);
      tick();
    end

    // Randomized stream under random backpressure
    for (int c = 0; c < 200; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      mode      = 2'($urandom_range(0, 3));
      in_ch     = CHW'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) in_data = ISZ'($urandom);
      else in_data = ISZ'(int'($urandom_range(0, 8191)) - 4096);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("a_all_beats_emerged", qa.size(), 0);
    check("b_all_beats_emerged", qb.size(), 0);

    // Statistics
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_count_a", int'(count_a), 0);
    check("clr_flags_a", int'(flags_a), 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      send(SAT_UCLAMP, 20000, 2'd2);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("count_a_saturates", int'(count_a), 15);
    check("flags_a_ch2", int'(flags_a), 4'b0100);
    check("count_b_20", int'(count_b), 20);
    check("flags_b_ch2", int'(flags_b), 4'b0100);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_alone_count", int'(count_a), 0);
    check("clr_alone_flags", int'(flags_a), 0);
    tick();
    send(SAT_UCLAMP, 20000, 2'd1);
    tick();
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_evt_count_a", int'(count_a), 1);
    check("clr_evt_flags_a", int'(flags_a), 4'b0010);
    check("clr_evt_count_b", int'(count_b), 1);
    check("clr_evt_flags_b", int'(flags_b), 4'b0010);
    tick();

    // Reset with two beats in flight
    send(SAT_UCLAMP, 5000, 2'd3);
    tick();
    send(SAT_UCLAMP, 5000, 2'd0);
    tick();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_out_valid_a", int'(ifa.out_valid), 0);
    check("midrst_out_valid_b", int'(ifb.out_valid), 0);
    check("midrst_count_a", int'(count_a), 0);
    check("midrst_flags_a", int'(flags_a), 0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_beat_a", int'(ifa.out_valid), 0);
      check("no_stale_beat_b", int'(ifb.out_valid), 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
